// File: rtl/types_pkg.sv
// Shared fetch-path types and constants.
// word_t is the 32-bit instruction/PC word; NOP_INSTR is the bubble
// (addi x0,x0,0) placed in Decode on reset or flush.
package types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t NOP_INSTR        = 32'h0000_0013;
    localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: generic W-bit register with load enable,
// synchronous clear, and asynchronous active-high reset to RST_VAL.
// Ports: clk, reset, en (load when 1), clr (load RST_VAL, wins over en), d, q.
module if_id_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // A flush and a reset leave the register in the same bubble state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC priority mux
// (redirect > stall_f > PC+PC_STEP) and the IF/ID register.
// Ports: clk/reset; hazard controls stall_f, stall_d, flush_d;
// redirect/redirect_pc from Execute; imem_addr/imem_rdata to a
// combinational instruction memory; pc_f plus the Decode-side bundle
// instr_d, pc_d, pc_plus_d, valid_d, misalign_d.
module if_stage
    import types_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus_d,
    output logic            valid_d,
    output logic            misalign_d
);

    localparam logic [XLEN-1:0] STEP  = XLEN'(PC_STEP);
    // PC_STEP is a power of two, so STEP-1 selects exactly the low
    // log2(PC_STEP) bits that a redirect target must have cleared.
    localparam logic [XLEN-1:0] ALIGN_MASK = STEP - 1'b1;
    localparam logic [XLEN-1:0] NOP_X      = XLEN'(NOP_INSTR);

    localparam int            DW     = 3 * XLEN + 2;
    localparam logic [DW-1:0] D_IDLE = {NOP_X, {XLEN{1'b0}}, {XLEN{1'b0}}, 2'b00};

    logic            misalign_f;
    logic [XLEN-1:0] pc_next;
    logic            misalign_next;
    logic [XLEN-1:0] pc_f_plus;

    // Plain XLEN-bit addition wraps modulo 2^XLEN with no carry out.
    assign pc_f_plus = pc_f + STEP;
    assign imem_addr = pc_f;

    always_comb begin
        pc_next       = pc_f;
        misalign_next = misalign_f;
        if (redirect) begin
            pc_next       = redirect_pc & ~ALIGN_MASK;
            misalign_next = |(redirect_pc & ALIGN_MASK);
        end else if (!stall_f) begin
            pc_next       = pc_f_plus;
            misalign_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f       <= RESET_PC;
            misalign_f <= 1'b0;
        end else begin
            pc_f       <= pc_next;
            misalign_f <= misalign_next;
        end
    end

    logic [DW-1:0] d_in;
    logic [DW-1:0] d_q;

    assign d_in = {imem_rdata, pc_f, pc_f_plus, 1'b1, misalign_f};

    if_id_reg #(
        .W       (DW),
        .RST_VAL (D_IDLE)
    ) u_if_id (
        .clk   (clk),
        .reset (reset),
        .en    (!stall_d),
        .clr   (flush_d),
        .d     (d_in),
        .q     (d_q)
    );

    assign {instr_d, pc_d, pc_plus_d, valid_d, misalign_d} = d_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance under main test
    logic        reset;
    logic        stall_f, stall_d, flush_d, redirect;
    logic [31:0] redirect_pc;
    wire  [31:0] imem_addr, pc_f, instr_d, pc_d, pc_plus_d;
    wire  [31:0] imem_rdata;
    wire         valid_d, misalign_d;

    assign imem_rdata = 32'hA0 + imem_addr;

    if_stage u32 (
        .clk         (clk),
        .reset       (reset),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .pc_f        (pc_f),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus_d   (pc_plus_d),
        .valid_d     (valid_d),
        .misalign_d  (misalign_d)
    );

    // 16-bit instance for the wrap-around check
    logic        zero1  = 1'b0;
    logic [15:0] zero16 = 16'h0;
    wire  [15:0] a16, r16, pf16, i16, pd16, pp16;
    wire         v16, m16;

    assign r16 = 16'hA0 + a16;

    if_stage #(.XLEN(16), .RESET_PC(16'hFFF8), .PC_STEP(4)) u16 (
        .clk         (clk),
        .reset       (reset),
        .stall_f     (zero1),
        .stall_d     (zero1),
        .flush_d     (zero1),
        .redirect    (zero1),
        .redirect_pc (zero16),
        .imem_addr   (a16),
        .imem_rdata  (r16),
        .pc_f        (pf16),
        .instr_d     (i16),
        .pc_d        (pd16),
        .pc_plus_d   (pp16),
        .valid_d     (v16),
        .misalign_d  (m16)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pcd, input logic [31:0] e_pcp,
                           input logic e_v, input logic e_m);
        chk({tag, " pc_f"},       pc_f,        e_pc);
        chk({tag, " imem_addr"},  imem_addr,   e_pc);
        chk({tag, " instr_d"},    instr_d,     e_instr);
        chk({tag, " pc_d"},       pc_d,        e_pcd);
        chk({tag, " pc_plus_d"},  pc_plus_d,   e_pcp);
        chk({tag, " valid_d"},    {31'b0, valid_d},    {31'b0, e_v});
        chk({tag, " misalign_d"}, {31'b0, misalign_d}, {31'b0, e_m});
    endtask

    typedef struct {
        logic        sf, sd, fl, rd;
        logic [31:0] rpc;
        logic [31:0] e_pc, e_instr, e_pcd, e_pcp;
        logic        e_v, e_m;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic sf, input logic sd, input logic fl, input logic rd,
                       input logic [31:0] rpc, input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic [31:0] e_pcd, input logic [31:0] e_pcp,
                       input logic e_v, input logic e_m);
        vec_t v;
        v.sf = sf; v.sd = sd; v.fl = fl; v.rd = rd; v.rpc = rpc;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_pcd = e_pcd; v.e_pcp = e_pcp;
        v.e_v = e_v; v.e_m = e_m;
        vecs.push_back(v);
    endtask

    // Behavioural reference model state
    longint unsigned m_pc, m_pcd, m_pcp, m_instr;
    logic            m_mis, m_v, m_misd;
    localparam longint unsigned MOD = 64'h1_0000_0000;

    initial begin
        reset = 1'b1;
        stall_f = 0; stall_d = 0; flush_d = 0; redirect = 0; redirect_pc = '0;

        //            sf sd fl rd rpc      pc_f     instr    pc_d     pc_plus  v  m
        add(0, 0, 0, 0, 32'h0,   32'h04,  32'hA0,  32'h00,  32'h04,  1, 0);
        add(0, 0, 0, 0, 32'h0,   32'h08,  32'hA4,  32'h04,  32'h08,  1, 0);
        add(1, 1, 0, 0, 32'h0,   32'h08,  32'hA4,  32'h04,  32'h08,  1, 0);
        add(1, 1, 0, 0, 32'h0,   32'h08,  32'hA4,  32'h04,  32'h08,  1, 0);
        add(0, 0, 0, 0, 32'h0,   32'h0C,  32'hA8,  32'h08,  32'h0C,  1, 0);
        add(0, 0, 1, 1, 32'h40,  32'h40,  32'h13,  32'h00,  32'h00,  0, 0);
        add(0, 0, 0, 0, 32'h0,   32'h44,  32'hE0,  32'h40,  32'h44,  1, 0);
        add(0, 0, 0, 1, 32'h42,  32'h40,  32'hE4,  32'h44,  32'h48,  1, 0);
        add(0, 0, 0, 0, 32'h0,   32'h44,  32'hE0,  32'h40,  32'h44,  1, 1);
        add(0, 0, 0, 0, 32'h0,   32'h48,  32'hE4,  32'h44,  32'h48,  1, 0);
        add(0, 1, 0, 0, 32'h0,   32'h4C,  32'hE4,  32'h44,  32'h48,  1, 0);
        add(0, 1, 1, 0, 32'h0,   32'h50,  32'h13,  32'h00,  32'h00,  0, 0);
        add(1, 0, 0, 1, 32'h103, 32'h100, 32'hF0,  32'h50,  32'h54,  1, 0);
        add(0, 0, 0, 0, 32'h0,   32'h104, 32'h1A0, 32'h100, 32'h104, 1, 1);

        // Reset state
        #12;
        chk_all("reset", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            stall_f = vecs[i].sf; stall_d = vecs[i].sd;
            flush_d = vecs[i].fl; redirect = vecs[i].rd; redirect_pc = vecs[i].rpc;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                    vecs[i].e_pcd, vecs[i].e_pcp, vecs[i].e_v, vecs[i].e_m);
        end

        // Reset asserted between edges with redirect/flush pending
        stall_f = 0; stall_d = 0; flush_d = 1; redirect = 1; redirect_pc = 32'h200;
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        chk_all("held_rst", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0; redirect = 0; flush_d = 0; redirect_pc = '0;
        tick();
        chk_all("first_edge", 32'h4, 32'hA0, 32'h0, 32'h4, 1'b1, 1'b0);
        chk("w16 pc_f e1", {16'h0, pf16}, 32'hFFFC);
        chk("w16 valid e1", {31'b0, v16}, 32'h1);
        tick();
        chk_all("second_edge", 32'h8, 32'hA4, 32'h4, 32'h8, 1'b1, 1'b0);
        chk("w16 pc_f wrap", {16'h0, pf16}, 32'h0);
        chk("w16 pc_d", {16'h0, pd16}, 32'hFFFC);
        chk("w16 pc_plus wrap", {16'h0, pp16}, 32'h0);
        chk("w16 instr", {16'h0, i16}, 32'h009C);

        // Randomised phase against reference model
        m_pc = 64'h8; m_mis = 0;
        m_instr = 64'hA4; m_pcd = 64'h4; m_pcp = 64'h8; m_v = 1; m_misd = 0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] tgt;
            stall_f  = ($urandom_range(0, 3) == 0);
            stall_d  = ($urandom_range(0, 3) == 0);
            flush_d  = ($urandom_range(0, 5) == 0);
            redirect = ($urandom_range(0, 4) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            redirect_pc = tgt;

            // Decode side
            if (flush_d) begin
                m_instr = 64'h13; m_pcd = 0; m_pcp = 0; m_v = 0; m_misd = 0;
            end else if (!stall_d) begin
                m_instr = (m_pc + 64'hA0) % MOD;
                m_pcd   = m_pc;
                m_pcp   = (m_pc + 4) % MOD;
                m_v     = 1;
                m_misd  = m_mis;
            end
            // Fetch side
            if (redirect) begin
                m_pc  = longint'(tgt) - (longint'(tgt) % 4);
                m_mis = (longint'(tgt) % 4) != 0;
            end else if (!stall_f) begin
                m_pc  = (m_pc + 4) % MOD;
                m_mis = 0;
            end

            tick();
            chk_all($sformatf("rnd%0d", n), m_pc[31:0], m_instr[31:0], m_pcd[31:0],
                    m_pcp[31:0], m_v, m_misd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
